// File: rtl/sched_select_pkg.sv
// rtl/sched_select_pkg.sv - shared sizes and index types for the select stage
package sched_select_pkg;

  localparam int NUM_ROWS = 8;
  localparam int NUM_FUS  = 4;
  localparam int ROW_W    = $clog2(NUM_ROWS);
  localparam int FU_W     = $clog2(NUM_FUS);

  typedef logic [ROW_W-1:0]    row_idx_t;
  typedef logic [FU_W-1:0]     fu_idx_t;
  typedef logic [NUM_ROWS-1:0] row_vec_t;
  typedef logic [NUM_FUS-1:0]  fu_vec_t;

  // One-hot row mask for a row index
  function automatic row_vec_t row_onehot(input row_idx_t idx);
    row_onehot      = '0;
    row_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/sched_select_if.sv
// rtl/sched_select_if.sv - dispatch/wakeup/issue bundle between scheduler and select stage
interface sched_select_if;
  import sched_select_pkg::*;

  logic                      flush;
  logic                      alloc_en;
  row_idx_t                  alloc_row;
  fu_idx_t                   alloc_fu;
  row_vec_t                  request_vector;
  fu_vec_t                   grant_valid;
  logic [NUM_FUS*ROW_W-1:0]  grant_row;
  fu_vec_t                   issue_ready;
  row_vec_t                  free_vec;
  logic                      alloc_err;

  modport master (
    output flush, alloc_en, alloc_row, alloc_fu, request_vector, issue_ready,
    input  grant_valid, grant_row, free_vec, alloc_err
  );

  modport slave (
    input  flush, alloc_en, alloc_row, alloc_fu, request_vector, issue_ready,
    output grant_valid, grant_row, free_vec, alloc_err
  );

endinterface

// File: rtl/sched_age_matrix.sv
// rtl/sched_age_matrix.sv - row age matrix with per-FU oldest-candidate pick
module sched_age_matrix
  import sched_select_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_flush,
  input  logic                              i_alloc_en,
  input  row_idx_t                          i_alloc_row,
  input  row_vec_t                          i_valid_after_free,
  input  row_vec_t                          i_free,
  input  logic [NUM_FUS-1:0][NUM_ROWS-1:0]  i_cand,
  output logic [NUM_FUS-1:0][ROW_W-1:0]     o_pick,
  output fu_vec_t                           o_pick_valid
);

  // r_older[r][c] = 1 : row c was allocated before row r (both still live)
  logic [NUM_ROWS-1:0][NUM_ROWS-1:0] r_older;

  // Freed rows drop out of every column; a new row is older-than nobody
  // and younger than every row that survives this cycle's frees
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_older <= '0;
    end else begin
      for (int c = 0; c < NUM_ROWS; c++) begin
        if (i_free[c]) begin
          for (int r = 0; r < NUM_ROWS; r++) begin
            r_older[r][c] <= 1'b0;
          end
        end
      end
      if (i_alloc_en) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
          r_older[r][i_alloc_row] <= 1'b0;
        end
        r_older[i_alloc_row] <= i_valid_after_free & ~row_onehot(i_alloc_row);
      end
    end
  end

  // Oldest candidate per FU: the one candidate with no older candidate
  always_comb begin
    o_pick       = '0;
    o_pick_valid = '0;
    for (int f = 0; f < NUM_FUS; f++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (i_cand[f][r] && ((i_cand[f] & r_older[r]) == '0)) begin
          o_pick[f]       = row_idx_t'(r);
          o_pick_valid[f] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sched_select.sv
// rtl/sched_select.sv - oldest-ready select with registered per-FU grants and row recycling
module sched_select
  import sched_select_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  sched_select_if.slave   bus
);

  row_vec_t                          r_valid;
  row_vec_t                          r_pending;
  fu_idx_t                           r_fu_id [NUM_ROWS];
  fu_vec_t                           r_grant_valid;
  logic [NUM_FUS-1:0][ROW_W-1:0]     r_grant_row;
  row_vec_t                          r_free_vec;
  logic                              r_alloc_err;

  fu_vec_t                           w_issue;
  fu_vec_t                           w_load;
  row_vec_t                          w_freed;
  row_vec_t                          w_valid_after_free;
  row_vec_t                          w_alloc_mask;
  logic                              w_alloc_ok;
  logic                              w_alloc_bad;
  logic [NUM_FUS-1:0][NUM_ROWS-1:0]  w_cand;
  logic [NUM_FUS-1:0][ROW_W-1:0]     w_pick;
  fu_vec_t                           w_pick_valid;
  row_vec_t                          w_pick_set;

  // Handshakes free their rows this cycle; an alloc may reuse such a row
  always_comb begin
    w_issue = r_grant_valid & bus.issue_ready;
    w_load  = ~r_grant_valid | bus.issue_ready;
    w_freed = '0;
    for (int f = 0; f < NUM_FUS; f++) begin
      if (w_issue[f]) begin
        w_freed[r_grant_row[f]] = 1'b1;
      end
    end
    w_valid_after_free = r_valid & ~w_freed;
    w_alloc_ok   = bus.alloc_en & ~w_valid_after_free[bus.alloc_row];
    w_alloc_bad  = bus.alloc_en &  w_valid_after_free[bus.alloc_row];
    w_alloc_mask = w_alloc_ok ? row_onehot(bus.alloc_row) : '0;
  end

  // Requesting, live, not-yet-granted rows split by their target FU
  always_comb begin
    w_cand = '0;
    for (int f = 0; f < NUM_FUS; f++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        w_cand[f][r] = bus.request_vector[r] & r_valid[r] & ~r_pending[r] &
                       (r_fu_id[r] == fu_idx_t'(f));
      end
    end
  end

  sched_age_matrix u_age (
    .clk                (clk),
    .rst                (rst),
    .i_flush            (bus.flush),
    .i_alloc_en         (w_alloc_ok),
    .i_alloc_row        (bus.alloc_row),
    .i_valid_after_free (w_valid_after_free),
    .i_free             (w_freed),
    .i_cand             (w_cand),
    .o_pick             (w_pick),
    .o_pick_valid       (w_pick_valid)
  );

  // Rows picked by an FU whose grant register can take a new value
  always_comb begin
    w_pick_set = '0;
    for (int f = 0; f < NUM_FUS; f++) begin
      if (w_load[f] && w_pick_valid[f]) begin
        w_pick_set[w_pick[f]] = 1'b1;
      end
    end
  end

  // Row valid/pending: frees clear, picks mark pending, allocs start fresh
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_valid   <= '0;
      r_pending <= '0;
    end else begin
      r_valid   <= w_valid_after_free | w_alloc_mask;
      r_pending <= ((r_pending & ~w_freed) | w_pick_set) & ~w_alloc_mask;
    end
  end

  // Target FU recorded at allocation
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        r_fu_id[r] <= '0;
      end
    end else if (!bus.flush && w_alloc_ok) begin
      r_fu_id[bus.alloc_row] <= bus.alloc_fu;
    end
  end

  // Grant registers reload when empty or when the FU takes the grant
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_grant_valid <= '0;
      r_grant_row   <= '0;
    end else begin
      for (int f = 0; f < NUM_FUS; f++) begin
        if (w_load[f]) begin
          r_grant_valid[f] <= w_pick_valid[f];
          r_grant_row[f]   <= w_pick[f];
        end
      end
    end
  end

  // Free pulses to wakeup one cycle after each handshake
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_free_vec <= '0;
    end else begin
      r_free_vec <= w_freed;
    end
  end

  // Sticky error for an alloc that hits a live row; only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alloc_err <= 1'b0;
    end else if (!bus.flush && w_alloc_bad) begin
      r_alloc_err <= 1'b1;
    end
  end

  assign bus.grant_valid = r_grant_valid;
  assign bus.grant_row   = r_grant_row;
  assign bus.free_vec    = r_free_vec;
  assign bus.alloc_err   = r_alloc_err;

endmodule

// File: doc/sched_select.md
Name: sched_select

Overview:
- Select stage directly downstream of the scheduler wakeup logic.
- Consumes the per-row request vector and picks, per functional unit, the oldest ready entry. Age is tracked in an internal age matrix.
- Holds one registered grant per FU under a valid/ready handshake to issue.
- Returns per-row free pulses to the wakeup logic so it can recycle entries.

Parameters:
- NUM_ROWS, 8, scheduler entries (power of two, ≥2)
- NUM_FUS, 4, functional units / issue ports

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  drop all entries and grants
- alloc_en  in  1  dispatch writes an entry this cycle
- alloc_row  in  log2(NUM_ROWS)  row being allocated
- alloc_fu  in  log2(NUM_FUS)  FU the entry must issue to
- request_vector  in  NUM_ROWS  per-row ready request from wakeup
- grant_valid  out  NUM_FUS  grant held for FU f
- grant_row  out  NUM_FUS*log2(NUM_ROWS)  granted row for FU f, packed, FU0 in LSBs
- issue_ready  in  NUM_FUS  FU f accepts its grant this cycle
- free_vec  out  NUM_ROWS  one-cycle pulse, row released to wakeup
- alloc_err  out  1  sticky: alloc to an already-valid row

Behaviour:
- State per row: valid, pending (granted, not yet issued), fu_id.
- State per FU: grant_valid, grant_row.
- Age matrix: older[r][c] = 1 means row c is older than row r.
- Reset / flush: clears all of the following next cycle.
  - valid, pending, older, grant_valid, free_vec → 0.
  - grant_row → 0.
  - alloc_err → 0, on rst only; flush leaves it unchanged.
  - Flush overrides alloc, grant and handshake in the same cycle.
- Allocation, alloc_en with valid[alloc_row]=0:
  - Next cycle: valid=1, pending=0, fu_id=alloc_fu.
  - older[alloc_row][c] = valid[c] after this cycle's frees, for c≠alloc_row.
  - older[c][alloc_row] = 0 for all c.
  - The new row is therefore the youngest.
- Allocation, alloc_en with valid[alloc_row]=1: ignored, alloc_err set.
  - Exception: a row being issued this same cycle counts as free, so the alloc succeeds.
- Candidate set for FU f: cand_f[r] = request_vector[r] & valid[r] & ~pending[r] & (fu_id[r]==f).
- Pick: row r with cand_f[r] and no c with cand_f[c] & older[r][c]. Unique by construction.
- Grant register, when grant_valid[f]=0 or (grant_valid[f] & issue_ready[f]):
  - Load grant_valid[f]=|cand_f and grant_row[f]=pick.
  - Set pending[pick].
  - Latency: request in cycle N gives grant_valid in cycle N+1.
  - Back-to-back issue at one grant per FU per cycle is supported.
- Grant register, otherwise: hold grant_valid[f] and grant_row[f] stable; FU f makes no new pick.
- Handshake: grant_valid[f] & issue_ready[f] at edge N clears valid and pending of grant_row[f]; free_vec[row]=1 in cycle N+1 only.
  - Multiple FUs may free in the same cycle.
- A row allocated in cycle N is not a candidate before cycle N+1.
- A pending row ignores request_vector, so dropping the request after grant has no effect.
- issue_ready is ignored when grant_valid=0.
- An alloc colliding with an issuing row gets fresh age and fu_id; the free_vec pulse for that row still fires.
- All selection logic is combinational from registered state plus request_vector. All outputs are registered.

Decomposition:
- CORE_PKG gets NUM_ROWS, NUM_FUS, row_idx_t (log2 NUM_ROWS), fu_idx_t (log2 NUM_FUS).
- Sub-module sched_age_matrix holds:
  - the older[][] flops;
  - alloc/free update;
  - the oldest-pick function, one combinational pick output per FU from a candidate vector.
- The top level holds valid/pending/fu_id, grant registers, handshake and free_vec.

Test Plan:
- Age order: alloc rows 3,1,5 to FU0 in consecutive cycles, then request_vector=8'b0010_1010 → grants row 3, 1, 5 on successive cycles with issue_ready=1. free_vec pulses 0x08, 0x02, 0x20 one cycle after each handshake.
- Backpressure: grant row 2 on FU1 with issue_ready=0 for 3 cycles while row 4 (FU1) also requests → grant_row stays 2, row 4 not granted. Raise ready → row 4 granted next cycle.
- Parallel FUs: rows 0/1/2/3 on FU0..FU3, all requesting in one cycle → all four grant_valid=1 next cycle. All issue together → free_vec=0x0F.
- Collision: alloc row 6 in the same cycle row 6 issues on FU2 → no alloc_err, free_vec[6] pulses, row 6 valid and youngest.
- Illegal alloc to valid row 7 → alloc_err=1 and held. Row 7 keeps its original fu_id and age.
- Flush with 3 held grants → next cycle grant_valid=0, all rows invalid, no free_vec pulses. rst mid-operation clears alloc_err.
